// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency mult/div sequencing, HI/LO
// registers, mthi/mtlo writes and the pipeline stall request.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   opa, opb;
    logic [1:0]      opl;
    logic            launch_c, done_c;

    logic            sgn_c, neg_a_c, neg_b_c;
    logic [2*DW-1:0] ext_a_c, ext_b_c, prod_c;
    logic [DW-1:0]   mag_a_c, mag_b_c, quot_m_c, rem_m_c, quot_c, rem_c;

    // Next-state and counter control
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        launch_c  = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !op[2]) begin
                    launch_c  = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Result arithmetic on latched operands; opl[0]=0 selects the signed form
    always_comb begin
        sgn_c    = ~opl[0];
        neg_a_c  = sgn_c & opa[DW-1];
        neg_b_c  = sgn_c & opb[DW-1];
        ext_a_c  = {{DW{neg_a_c}}, opa};
        ext_b_c  = {{DW{neg_b_c}}, opb};
        prod_c   = ext_a_c * ext_b_c;
        mag_a_c  = neg_a_c ? (DW'(0) - opa) : opa;
        mag_b_c  = neg_b_c ? (DW'(0) - opb) : opb;
        quot_m_c = (mag_b_c == '0) ? '0 : mag_a_c / mag_b_c;
        rem_m_c  = (mag_b_c == '0) ? '0 : mag_a_c % mag_b_c;
        quot_c   = (neg_a_c ^ neg_b_c) ? (DW'(0) - quot_m_c) : quot_m_c;
        rem_c    = neg_a_c ? (DW'(0) - rem_m_c) : rem_m_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opa <= '0;
            opb <= '0;
            opl <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            if (launch_c) begin
                opa <= rs;
                opb <= rt;
                opl <= op[1:0];
            end
            if (done_c) begin
                if (!opl[1]) begin
                    hi <= prod_c[2*DW-1:DW];
                    lo <= prod_c[DW-1:0];
                end else if (opb != '0) begin
                    hi <= rem_c;
                    lo <= quot_c;
                end
            end else if (state == IDLE && start) begin
                if (op == 3'd4) hi <= rs;
                if (op == 3'd5) lo <= rs;
            end
        end
    end

    assign busy     = (state == BUSY);
    assign stall_md = d_is_md & (busy | (start & ~op[2]));

endmodule
